scratchpad_memory: RTL and testbench

SCRATCHPAD_MEMORY -- requirements
Module: scratchpad_memory

---
 rtl/Bundle.sv | 59 +++++
 rtl/LoadStoreAlign.sv | 49 ++++
 rtl/scratchpad_memory.sv | 129 ++++++++++++
 tb/tb_scratchpad_memory.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/Bundle.sv
// Bundle: memory-port request/response types, scratchpad FSM states and the
// misalignment predicate shared by scratchpad_memory and LoadStoreAlign.
package Bundle;

    typedef enum logic {
        M_XRD = 1'b0,
        M_XWR = 1'b1
    } MemoryWriteSignal;

    typedef enum logic [2:0] {
        MT_X  = 3'd0,
        MT_B  = 3'd1,
        MT_H  = 3'd2,
        MT_W  = 3'd3,
        MT_BU = 3'd4,
        MT_HU = 3'd5,
        MT_WU = 3'd6
    } MemoryMaskType;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } ScratchpadState;

    typedef struct packed {
        logic [31:0]      addr;
        logic [31:0]      data;
        MemoryWriteSignal fcn;
        MemoryMaskType    typ;
    } MemoryReq;

    typedef struct packed {
        logic     req_valid;
        MemoryReq req;
    } MemoryIn;

    typedef struct packed {
        logic [31:0] data;
    } MemoryResp;

    typedef struct packed {
        logic      req_ready;
        logic      res_valid;
        MemoryResp res;
    } MemoryOut;

    // Bytes are always aligned; halfwords need addr[0]=0; everything else is a word.
    function automatic logic is_misaligned(input MemoryMaskType typ, input logic [1:0] addr_lo);
        logic mis;
        case (typ)
            MT_B, MT_BU: mis = 1'b0;
            MT_H, MT_HU: mis = addr_lo[0];
            default:     mis = (addr_lo != 2'b00);
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/LoadStoreAlign.sv
// LoadStoreAlign: byte-lane steering. Load mode extracts and extends a lane of
// old_word; store mode merges new_data's low bits into old_word's addressed lanes.
module LoadStoreAlign
    import Bundle::*;
(
    input  logic [1:0]    addr_lo,
    input  MemoryMaskType typ,
    input  logic          is_load,
    input  logic [31:0]   new_data,
    input  logic [31:0]   old_word,
    output logic [31:0]   result
);
    logic [3:0]  byte_en;
    logic [31:0] store_word;
    logic [31:0] bit_mask;
    logic [31:0] shifted;
    logic [31:0] load_word;

    always_comb begin
        byte_en    = 4'b1111;
        store_word = new_data;
        case (typ)
            MT_B, MT_BU: begin
                byte_en    = 4'b0001 << addr_lo;
                store_word = {4{new_data[7:0]}};
            end
            MT_H, MT_HU: begin
                byte_en    = addr_lo[1] ? 4'b1100 : 4'b0011;
                store_word = {2{new_data[15:0]}};
            end
            default: ;
        endcase
        bit_mask = {{8{byte_en[3]}}, {8{byte_en[2]}}, {8{byte_en[1]}}, {8{byte_en[0]}}};
    end

    // Shifting by the byte offset puts the addressed lane at bit 0 for every size.
    always_comb begin
        shifted = old_word >> {addr_lo, 3'b000};
        case (typ)
            MT_B:    load_word = {{24{shifted[7]}}, shifted[7:0]};
            MT_BU:   load_word = {24'b0, shifted[7:0]};
            MT_H:    load_word = {{16{shifted[15]}}, shifted[15:0]};
            MT_HU:   load_word = {16'b0, shifted[15:0]};
            default: load_word = old_word;
        endcase
        result = is_load ? load_word : ((old_word & ~bit_mask) | (store_word & bit_mask));
    end

endmodule

// File: rtl/scratchpad_memory.sv
// scratchpad_memory: single-port word array with byte/halfword access and one
// response per request. Define SCRATCHPAD_WAIT_STATES_EN to add WAIT_CYCLES of latency.
module scratchpad_memory
    import Bundle::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic     clk,
    input  logic     reset,
    input  MemoryIn  mem_in,
    output MemoryOut mem_out,
    output logic     xcpt_ma
);
    localparam int IDX_W = $clog2(DEPTH_WORDS);

    ScratchpadState   state_q, state_d;
    MemoryReq         req_q, req_d;
    logic             res_valid_q, res_valid_d;
    logic             req_ready_q, req_ready_d;
    logic             accept, wr_en, req_mis, resp_mis;
    logic [IDX_W-1:0] wr_idx, rd_idx;
    logic [31:0]      wr_old, wr_word, rd_word, ld_data;
    logic [31:0]      mem [DEPTH_WORDS];
    logic             unused_addr_hi;

`ifdef SCRATCHPAD_WAIT_STATES_EN
    localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES + 1) : 1;
    logic [CNT_W-1:0] cnt_q, cnt_d;
`else
    logic [31:0] unused_wait_cycles;
    assign unused_wait_cycles = WAIT_CYCLES;
`endif

    assign accept   = mem_in.req_valid && req_ready_q;
    assign req_mis  = is_misaligned(mem_in.req.typ, mem_in.req.addr[1:0]);
    assign resp_mis = is_misaligned(req_q.typ, req_q.addr[1:0]);
    assign wr_en    = accept && (mem_in.req.fcn == M_XWR) && !req_mis;
    assign wr_idx   = mem_in.req.addr[IDX_W+1:2];
    assign rd_idx   = req_q.addr[IDX_W+1:2];
    assign wr_old   = mem[wr_idx];
    assign rd_word  = mem[rd_idx];
    assign unused_addr_hi = ^{mem_in.req.addr[31:IDX_W+2], req_q.addr[31:IDX_W+2]};

    LoadStoreAlign u_store_align (
        .addr_lo  (mem_in.req.addr[1:0]),
        .typ      (mem_in.req.typ),
        .is_load  (1'b0),
        .new_data (mem_in.req.data),
        .old_word (wr_old),
        .result   (wr_word)
    );

    LoadStoreAlign u_load_align (
        .addr_lo  (req_q.addr[1:0]),
        .typ      (req_q.typ),
        .is_load  (1'b1),
        .new_data (req_q.data),
        .old_word (rd_word),
        .result   (ld_data)
    );

    // Writes commit at the accept edge so a following read always sees them.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_idx] <= wr_word;
    end

    always_comb begin
        state_d = state_q;
        req_d   = accept ? mem_in.req : req_q;
`ifdef SCRATCHPAD_WAIT_STATES_EN
        cnt_d   = cnt_q;
`endif
        case (state_q)
            IDLE, RESP: begin
                if (!accept) begin
                    state_d = IDLE;
`ifdef SCRATCHPAD_WAIT_STATES_EN
                end else if (WAIT_CYCLES != 0) begin
                    state_d = WAIT;
                    cnt_d   = CNT_W'(WAIT_CYCLES);
`endif
                end else begin
                    state_d = RESP;
                end
            end
`ifdef SCRATCHPAD_WAIT_STATES_EN
            WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) state_d = RESP;
            end
`endif
            default: state_d = IDLE;
        endcase
        res_valid_d = (state_d == RESP);
        req_ready_d = (state_d != WAIT);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            req_q       <= '0;
            res_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
`ifdef SCRATCHPAD_WAIT_STATES_EN
            cnt_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            req_q       <= req_d;
            res_valid_q <= res_valid_d;
            req_ready_q <= req_ready_d;
`ifdef SCRATCHPAD_WAIT_STATES_EN
            cnt_q       <= cnt_d;
`endif
        end
    end

    // Writes and misaligned accesses answer with zero data.
    always_comb begin
        mem_out           = '0;
        mem_out.req_ready = req_ready_q;
        mem_out.res_valid = res_valid_q;
        if (res_valid_q && (req_q.fcn == M_XRD) && !resp_mis) mem_out.res.data = ld_data;
    end

    assign xcpt_ma = res_valid_q && resp_mis;

endmodule

// File: tb/tb_scratchpad_memory.sv
// Self-checking bench for scratchpad_memory: directed accesses, a random
// shadow-model section, latency/ready timing and reset-abort behaviour.
module tb_scratchpad_memory;
    import Bundle::*;

    localparam int unsigned TB_DEPTH = 1024;
    localparam int unsigned TB_WAIT  = 2;
`ifdef SCRATCHPAD_WAIT_STATES_EN
    localparam int EXP_LAT = 1 + TB_WAIT;
`else
    localparam int EXP_LAT = 1;
`endif

    logic     clk;
    logic     reset;
    MemoryIn  mem_in;
    MemoryOut mem_out;
    logic     xcpt_ma;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    logic [32:0] exp_q[$];
    int          acc_q[$];
    string       tag_q[$];

    logic [32:0] mon_e;
    int          mon_a;
    string       mon_t;

    MemoryMaskType typs[6] = '{MT_B, MT_H, MT_W, MT_BU, MT_HU, MT_WU};
    logic [31:0]   shadow[8];
    int            r_w;
    logic [1:0]    r_off;
    MemoryMaskType r_t;
    logic [31:0]   r_addr, r_d;
    logic          r_mis;

    scratchpad_memory #(.DEPTH_WORDS(TB_DEPTH), .WAIT_CYCLES(TB_WAIT)) dut (
        .clk     (clk),
        .reset   (reset),
        .mem_in  (mem_in),
        .mem_out (mem_out),
        .xcpt_ma (xcpt_ma)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- checker ----------------
    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic tb_mis(input MemoryMaskType t, input logic [1:0] off);
        if (t == MT_B || t == MT_BU) return 1'b0;
        if (t == MT_H || t == MT_HU) return off[0];
        return off != 2'b00;
    endfunction

    function automatic logic [31:0] tb_load(input logic [31:0] w, input MemoryMaskType t, input logic [1:0] off);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[int'(off)*8 +: 8];
        h = off[1] ? w[31:16] : w[15:0];
        case (t)
            MT_B:    return {{24{b[7]}}, b};
            MT_BU:   return {24'h0, b};
            MT_H:    return {{16{h[15]}}, h};
            MT_HU:   return {16'h0, h};
            default: return w;
        endcase
    endfunction

    function automatic logic [31:0] tb_store(input logic [31:0] w, input MemoryMaskType t,
                                             input logic [1:0] off, input logic [31:0] d);
        logic [31:0] r;
        r = w;
        if (t == MT_B || t == MT_BU) r[int'(off)*8 +: 8] = d[7:0];
        else if (t == MT_H || t == MT_HU) begin
            if (off[1]) r[31:16] = d[15:0];
            else        r[15:0]  = d[15:0];
        end else r = d;
        return r;
    endfunction

    // ---------------- driver tasks (called at a negedge) ----------------
    task automatic send(input MemoryWriteSignal fcn, input MemoryMaskType typ, input logic [31:0] addr,
                        input logic [31:0] data, input logic [31:0] exp_data, input logic exp_ma,
                        input string tag);
        int n;
        n = 0;
        mem_in.req_valid = 1'b1;
        mem_in.req.addr  = addr;
        mem_in.req.data  = data;
        mem_in.req.fcn   = fcn;
        mem_in.req.typ   = typ;
        while (mem_out.req_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk_eq({tag, ".ready_timeout"}, {31'b0, mem_out.req_ready}, 32'd1);
        else begin
            exp_q.push_back({exp_ma, exp_data});
            acc_q.push_back(cyc);
            tag_q.push_back(tag);
        end
        @(negedge clk);
    endtask

    task automatic drain();
        int n;
        n = 0;
        mem_in.req_valid = 1'b0;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            chk_eq("drain_timeout", 32'(exp_q.size()), 32'd0);
            exp_q.delete();
            acc_q.delete();
            tag_q.delete();
        end
        @(negedge clk);
    endtask

    // Accept one request, then hit reset just after the accept edge.
    task automatic abort_with_reset(input MemoryWriteSignal fcn, input MemoryMaskType typ,
                                    input logic [31:0] addr, input logic [31:0] data);
        mem_in.req_valid = 1'b1;
        mem_in.req.addr  = addr;
        mem_in.req.data  = data;
        mem_in.req.fcn   = fcn;
        mem_in.req.typ   = typ;
        chk_eq("abort.ready_before", {31'b0, mem_out.req_ready}, 32'd1);
        @(posedge clk);
        #1;
        reset            = 1'b1;
        mem_in.req_valid = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk_eq("abort.res_valid", {31'b0, mem_out.res_valid}, 32'd0);
            chk_eq("abort.req_ready", {31'b0, mem_out.req_ready}, 32'd1);
            chk_eq("abort.data", mem_out.res.data, 32'd0);
        end
        reset = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    // ---------------- scoreboard / monitor ----------------
    always @(negedge clk) begin
        if (!reset) begin
            if (mem_out.res_valid) begin
                if (exp_q.size() == 0) chk_eq("spurious_res", {31'b0, mem_out.res_valid}, 32'd0);
                else begin
                    mon_e = exp_q.pop_front();
                    mon_a = acc_q.pop_front();
                    mon_t = tag_q.pop_front();
                    chk_eq({mon_t, ".data"}, mem_out.res.data, mon_e[31:0]);
                    chk_eq({mon_t, ".xcpt_ma"}, {31'b0, xcpt_ma}, {31'b0, mon_e[32]});
                    chk_eq({mon_t, ".latency"}, 32'(cyc - mon_a), 32'(EXP_LAT));
                end
            end else begin
                chk_eq("idle.data", mem_out.res.data, 32'd0);
                chk_eq("idle.xcpt_ma", {31'b0, xcpt_ma}, 32'd0);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        reset  = 1'b1;
        mem_in = '0;
        repeat (3) begin
            @(negedge clk);
            chk_eq("rst.req_ready", {31'b0, mem_out.req_ready}, 32'd1);
            chk_eq("rst.res_valid", {31'b0, mem_out.res_valid}, 32'd0);
            chk_eq("rst.data", mem_out.res.data, 32'd0);
            chk_eq("rst.xcpt_ma", {31'b0, xcpt_ma}, 32'd0);
        end
        reset = 1'b0;
        @(negedge clk);

        // word write then immediate read-back
        send(M_XWR, MT_W,  32'h10, 32'hDEADBEEF, 32'h0, 1'b0, "sw10");
        send(M_XRD, MT_W,  32'h10, 32'h0,        32'hDEADBEEF, 1'b0, "lw10");
        send(M_XRD, MT_B,  32'h13, 32'h0,        32'hFFFFFFDE, 1'b0, "lb13");
        send(M_XRD, MT_BU, 32'h13, 32'h0,        32'h000000DE, 1'b0, "lbu13");
        send(M_XRD, MT_H,  32'h12, 32'h0,        32'hFFFFDEAD, 1'b0, "lh12");
        send(M_XRD, MT_HU, 32'h10, 32'h0,        32'h0000BEEF, 1'b0, "lhu10");
        // byte store uses only the low data bits
        send(M_XWR, MT_B,  32'h11, 32'hFFFFFF55, 32'h0,        1'b0, "sb11");
        send(M_XRD, MT_W,  32'h10, 32'h0,        32'hDEAD55EF, 1'b0, "lw10_sb");
        // misaligned accesses: flagged, zero data, no update
        send(M_XRD, MT_W,  32'h12, 32'h0,        32'h0,        1'b1, "lw12_mis");
        send(M_XWR, MT_W,  32'h12, 32'h01234567, 32'h0,        1'b1, "sw12_mis");
        send(M_XWR, MT_H,  32'h13, 32'h00007777, 32'h0,        1'b1, "sh13_mis");
        send(M_XRD, MT_HU, 32'h11, 32'h0,        32'h0,        1'b1, "lhu11_mis");
        send(M_XRD, MT_W,  32'h10, 32'h0,        32'hDEAD55EF, 1'b0, "lw10_keep");
        // halfword store into the upper lane
        send(M_XWR, MT_W,  32'h20, 32'h11223344, 32'h0,        1'b0, "sw20");
        send(M_XWR, MT_H,  32'h22, 32'h0000BEEF, 32'h0,        1'b0, "sh22");
        send(M_XRD, MT_W,  32'h20, 32'h0,        32'hBEEF3344, 1'b0, "lw20");
        send(M_XRD, MT_H,  32'h22, 32'h0,        32'hFFFFBEEF, 1'b0, "lh22");
        send(M_XRD, MT_BU, 32'h20, 32'h0,        32'h00000044, 1'b0, "lbu20");
        send(M_XRD, MT_B,  32'h21, 32'h0,        32'h00000033, 1'b0, "lb21");
        // address wrap-around modulo DEPTH_WORDS*4
        send(M_XWR, MT_W,  32'h1000, 32'h12345678, 32'h0,      1'b0, "sw1000");
        send(M_XRD, MT_W,  32'h0,    32'h0,        32'h12345678, 1'b0, "lw0_wrap");
        drain();

        // random mix against the shadow model
        for (int i = 0; i < 8; i++) begin
            shadow[i] = $urandom;
            send(M_XWR, MT_W, 32'h200 + 32'(i * 4), shadow[i], 32'h0, 1'b0, "rnd_sw");
        end
        for (int k = 0; k < 40; k++) begin
            r_w    = $urandom_range(0, 7);
            r_off  = 2'($urandom_range(0, 3));
            r_t    = typs[$urandom_range(0, 5)];
            r_addr = 32'h200 + 32'(r_w * 4) + {30'b0, r_off};
            r_mis  = tb_mis(r_t, r_off);
            r_d    = $urandom;
            if ($urandom_range(0, 2) == 0) begin
                send(M_XWR, r_t, r_addr, r_d, 32'h0, r_mis, "rnd_st");
                if (!r_mis) shadow[r_w] = tb_store(shadow[r_w], r_t, r_off, r_d);
            end else begin
                send(M_XRD, r_t, r_addr, r_d, r_mis ? 32'h0 : tb_load(shadow[r_w], r_t, r_off), r_mis, "rnd_ld");
            end
        end
        drain();

        // ready/valid timing of one isolated read
        send(M_XRD, MT_W, 32'h10, 32'h0, 32'hDEAD55EF, 1'b0, "tm_lw");
        mem_in.req_valid = 1'b0;
        for (int i = 1; i <= EXP_LAT; i++) begin
            chk_eq("tm.req_ready", {31'b0, mem_out.req_ready}, {31'b0, i == EXP_LAT});
            chk_eq("tm.res_valid", {31'b0, mem_out.res_valid}, {31'b0, i == EXP_LAT});
            @(negedge clk);
        end
        drain();

        // reset mid-transaction: response dropped, committed write kept
        send(M_XWR, MT_W, 32'h40, 32'hCAFEF00D, 32'h0, 1'b0, "sw40");
        drain();
        abort_with_reset(M_XWR, MT_W, 32'h44, 32'hA5A5A5A5);
        abort_with_reset(M_XRD, MT_W, 32'h40, 32'h0);
        send(M_XRD, MT_W, 32'h40, 32'h0, 32'hCAFEF00D, 1'b0, "lw40_post");
        send(M_XRD, MT_W, 32'h44, 32'h0, 32'hA5A5A5A5, 1'b0, "lw44_post");
        send(M_XRD, MT_W, 32'h10, 32'h0, 32'hDEAD55EF, 1'b0, "lw10_post");
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
